// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/flush, with flush deferral and a stall watchdog.
// Stall/flush outputs are combinational; rdy low freezes the pipe and defers any flush.
module pipe_ctrl #(
    parameter int N_STAGES = 5,
    parameter int CNT_W    = 16,
    parameter int WDOG_LIM = 1023,
    localparam int SW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [N_STAGES-1:0] stall_req,
    input  logic                flush_req,
    input  logic [SW-1:0]       flush_stage,
    output logic [N_STAGES-1:0] stall_out,
    output logic [N_STAGES-1:0] flush_out,
    output logic                flush_pend,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic                wdog_err
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_PEND  = 1'b1;
    localparam logic [CNT_W-1:0] LIM     = CNT_W'(WDOG_LIM);
    localparam logic [CNT_W-1:0] LIM_M1  = CNT_W'(WDOG_LIM - 1);

    logic [0:0]       r_state;
    logic [SW-1:0]    r_pend_stage;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_wdog_cnt;
    logic             r_wdog_err;

    int   w_fs;
    int   w_ps;
    int   w_merged;
    int   w_fk;
    int   w_spt;
    logic w_fvalid;
    logic w_fire;
    logic w_svld;

    // Bits 0..k-1 set.
    function automatic logic [N_STAGES-1:0] below(input int k);
        logic [N_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (i < k) m[i] = 1'b1;
        end
        return m;
    endfunction

    always_comb begin
        w_fs     = int'(flush_stage);
        w_ps     = int'(r_pend_stage);
        w_fvalid = flush_req && (w_fs >= 1) && (w_fs < N_STAGES);
        w_merged = (w_fvalid && (w_fs > w_ps)) ? w_fs : w_ps;
        w_fire   = 1'b0;
        w_fk     = 0;
        // A flush may only fire once nothing at or beyond its resolving stage is holding.
        if (r_state == S_IDLE) begin
            if (rdy && w_fvalid && !(|(stall_req & ~below(w_fs)))) begin
                w_fire = 1'b1;
                w_fk   = w_fs;
            end
        end else if (rdy && !(|(stall_req & ~below(w_ps)))) begin
            w_fire = 1'b1;
            w_fk   = w_merged;
        end

        w_svld = 1'b0;
        w_spt  = 0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (stall_req[i] && !(w_fire && (i < w_fk))) begin
                w_svld = 1'b1;
                w_spt  = i;
            end
        end

        stall_out = '0;
        flush_out = '0;
        if (rst) begin
            stall_out = '0;
        end else if (!rdy) begin
            stall_out = '1;
        end else begin
            if (w_fire) flush_out = below(w_fk);
            if (w_svld) begin
                stall_out = below(w_spt + 1);
                // Bubble into the stage just past the stall point (vanishes past the oldest stage).
                flush_out = flush_out | (below(w_spt + 2) & ~below(w_spt + 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pend_stage   <= '0;
            r_stall_cycles <= '0;
            r_wdog_cnt     <= '0;
            r_wdog_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fvalid && !w_fire) begin
                        r_state      <= S_PEND;
                        r_pend_stage <= flush_stage;
                    end
                end
                default: begin
                    if (w_fire) begin
                        r_state      <= S_IDLE;
                        r_pend_stage <= '0;
                    end else if (w_fvalid && (w_fs > w_ps)) begin
                        r_pend_stage <= flush_stage;
                    end
                end
            endcase

            if (rdy) begin
                if (|stall_out) begin
                    if (r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
                    if (r_wdog_cnt < LIM) r_wdog_cnt <= r_wdog_cnt + 1'b1;
                    if (r_wdog_cnt == LIM_M1) r_wdog_err <= 1'b1;
                end else begin
                    r_wdog_cnt <= '0;
                end
            end
        end
    end

    assign flush_pend   = !rst && (r_state == S_PEND);
    assign stall_cycles = r_stall_cycles;
    assign wdog_err     = r_wdog_err;

endmodule
